// File: rtl/tnoc_config_pkg.sv
// Shared configuration for the NoC output scheduler: global config record,
// scheduler FSM states and width helper functions.
package tnoc_config_pkg;

    typedef struct packed {
        int unsigned virtual_channels;
    } tnoc_config_t;

    localparam tnoc_config_t CONFIG = '{virtual_channels: 32'd2};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } tnoc_sched_state_e;

    // Width of a credit counter able to hold 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of an index into n items, never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// Combinational round-robin picker: scans requests starting at index 'start'
// and wrapping at WIDTH-1, returning the first hit as one-hot and as an index.
import tnoc_config_pkg::*;

module tnoc_round_robin_arbiter #(
    parameter int WIDTH = 5,
    localparam int IW = index_width(WIDTH)
) (
    input  logic [WIDTH-1:0] request,
    input  logic [IW-1:0]    start,
    output logic [WIDTH-1:0] grant,
    output logic [IW-1:0]    grant_index,
    output logic             found
);

    int pos;

    // Walk every offset from the start index and take the first requester.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        pos         = 0;
        for (int k = 0; k < WIDTH; k++) begin
            pos = int'(start) + k;
            if (pos >= WIDTH) begin
                pos = pos - WIDTH;
            end
            if (!found && request[pos]) begin
                found       = 1'b1;
                grant[pos]  = 1'b1;
                grant_index = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/tnoc_output_credit_scheduler.sv
// Output-port scheduler: round-robin switch allocation across input ports
// with wormhole locking until the tail flit, plus per-VC credit tracking.
//
// Handshake: a port holds i_request until it sees its o_grant bit. While
// granted, each cycle with i_flit_fire high moves one flit on o_grant_vc and
// consumes one credit; the lock releases on the cycle where i_flit_fire and
// i_flit_tail are both high. The switch must itself stall when the granted
// VC shows no credit on o_vc_available.
import tnoc_config_pkg::*;

module tnoc_output_credit_scheduler #(
    parameter int PORTS    = 5,
    parameter int CHANNELS = int'(CONFIG.virtual_channels),
    parameter int DEPTH    = 4,
    localparam int VCW = index_width(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PORTS-1:0]       i_request,
    input  logic [PORTS*VCW-1:0]   i_request_vc,
    input  logic                   i_flit_fire,
    input  logic                   i_flit_tail,
    input  logic [CHANNELS-1:0]    i_credit_return,
    output logic [PORTS-1:0]       o_grant,
    output logic [VCW-1:0]         o_grant_vc,
    output logic [CHANNELS-1:0]    o_vc_available,
    output logic                   o_credit_error,
    output tnoc_sched_state_e      o_state
);

    localparam int PW = index_width(PORTS);
    localparam int CW = credit_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PORT = PW'(PORTS - 1);

    tnoc_sched_state_e state_q, state_d;
    logic [PORTS-1:0]  grant_d;
    logic [VCW-1:0]    grant_vc_d;
    logic [PW-1:0]     winner_q, winner_d;
    logic [PW-1:0]     last_q, last_d;
    logic [PW-1:0]     start;
    logic [CW-1:0]     credit_q [CHANNELS];
    logic [CW-1:0]     credit_d [CHANNELS];
    logic [CHANNELS-1:0] dec_vc;
    logic              err_set;
    logic              error_q;
    logic [(1<<VCW)-1:0] avail_pad;
    logic [PORTS-1:0]  eligible;
    logic [PORTS-1:0]  arb_grant;
    logic [PW-1:0]     arb_index;
    logic              arb_found;

    // A VC is available whenever its registered credit count is nonzero.
    always_comb begin
        for (int v = 0; v < CHANNELS; v++) begin
            o_vc_available[v] = (credit_q[v] != '0);
        end
    end

    // A port is eligible when it requests and its chosen VC has credit;
    // the padded vector keeps out-of-range VC codes ineligible.
    always_comb begin
        avail_pad                 = '0;
        avail_pad[CHANNELS-1:0]   = o_vc_available;
        for (int p = 0; p < PORTS; p++) begin
            eligible[p] = i_request[p] && avail_pad[i_request_vc[p*VCW +: VCW]];
        end
    end

    // Search starts one past the last winner, wrapping at the top port.
    always_comb begin
        start = (last_q == LAST_PORT) ? '0 : last_q + PW'(1);
    end

    tnoc_round_robin_arbiter #(
        .WIDTH (PORTS)
    ) u_arbiter (
        .request     (eligible),
        .start       (start),
        .grant       (arb_grant),
        .grant_index (arb_index),
        .found       (arb_found)
    );

    // Next-state logic: grant from IDLE, hold the lock in BUSY until a tail fires.
    always_comb begin
        state_d    = state_q;
        grant_d    = o_grant;
        grant_vc_d = o_grant_vc;
        winner_d   = winner_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = BUSY;
                    grant_d    = arb_grant;
                    grant_vc_d = i_request_vc[arb_index*VCW +: VCW];
                    winner_d   = arb_index;
                end else begin
                    grant_d = '0;
                end
            end
            BUSY: begin
                if (i_flit_fire && i_flit_tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = winner_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Which VC loses a credit this cycle: only flits fired under a grant count.
    always_comb begin
        dec_vc = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            dec_vc[v] = i_flit_fire && (state_q == BUSY) && (o_grant_vc == VCW'(v));
        end
    end

    // Credit update with saturation; any clipped update or idle fire is an error.
    always_comb begin
        err_set = i_flit_fire && (state_q == IDLE);
        for (int v = 0; v < CHANNELS; v++) begin
            credit_d[v] = credit_q[v];
            if (dec_vc[v] && !i_credit_return[v]) begin
                if (credit_q[v] == '0) begin
                    err_set = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] - CW'(1);
                end
            end else if (i_credit_return[v] && !dec_vc[v]) begin
                if (credit_q[v] == DEPTH_C) begin
                    err_set = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    // State, grant, pointer, credit and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            o_grant    <= '0;
            o_grant_vc <= '0;
            winner_q   <= '0;
            last_q     <= LAST_PORT;
            error_q    <= 1'b0;
            for (int v = 0; v < CHANNELS; v++) begin
                credit_q[v] <= DEPTH_C;
            end
        end else begin
            state_q    <= state_d;
            o_grant    <= grant_d;
            o_grant_vc <= grant_vc_d;
            winner_q   <= winner_d;
            last_q     <= last_d;
            error_q    <= error_q | err_set;
            for (int v = 0; v < CHANNELS; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign o_credit_error = error_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_tnoc_output_credit_scheduler.sv
// Directed bench for the output credit scheduler with default parameters
// (5 ports, 2 VCs, depth 4). Inputs change 1 time unit after a rising edge
// and outputs are checked at the same point, one edge after stimulus.
import tnoc_config_pkg::*;

module tb_tnoc_output_credit_scheduler;

    logic              clk;
    logic              rst_n;
    logic [4:0]        i_request;
    logic [4:0]        i_request_vc;
    logic              i_flit_fire;
    logic              i_flit_tail;
    logic [1:0]        i_credit_return;
    logic [4:0]        o_grant;
    logic [0:0]        o_grant_vc;
    logic [1:0]        o_vc_available;
    logic              o_credit_error;
    tnoc_sched_state_e o_state;

    int total;
    int bad;

    tnoc_output_credit_scheduler #(
        .PORTS    (5),
        .CHANNELS (2),
        .DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_request       (i_request),
        .i_request_vc    (i_request_vc),
        .i_flit_fire     (i_flit_fire),
        .i_flit_tail     (i_flit_tail),
        .i_credit_return (i_credit_return),
        .o_grant         (o_grant),
        .o_grant_vc      (o_grant_vc),
        .o_vc_available  (o_vc_available),
        .o_credit_error  (o_credit_error),
        .o_state         (o_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive reset for two edges with all inputs quiet, then release.
    task automatic do_reset();
        rst_n           = 1'b0;
        i_request       = '0;
        i_request_vc    = '0;
        i_flit_fire     = 1'b0;
        i_flit_tail     = 1'b0;
        i_credit_return = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (o_grant !== 5'b00000) begin
            bad++; $display("FAIL reset_grant: got=%b exp=%b", o_grant, 5'b00000);
        end
        total++;
        if (o_grant_vc !== 1'b0) begin
            bad++; $display("FAIL reset_grant_vc: got=%b exp=%b", o_grant_vc, 1'b0);
        end
        total++;
        if (o_vc_available !== 2'b11) begin
            bad++; $display("FAIL reset_vc_available: got=%b exp=%b", o_vc_available, 2'b11);
        end
        total++;
        if (o_credit_error !== 1'b0) begin
            bad++; $display("FAIL reset_error: got=%b exp=%b", o_credit_error, 1'b0);
        end
        total++;
        if (o_state !== IDLE) begin
            bad++; $display("FAIL reset_state: got=%0d exp=%0d", o_state, IDLE);
        end
    endtask

    task automatic test_basic_grant();
        do_reset();
        i_request = 5'b00101;
        tick();
        total++;
        if (o_grant !== 5'b00001) begin
            bad++; $display("FAIL basic_first_grant: got=%b exp=%b", o_grant, 5'b00001);
        end
        total++;
        if (o_state !== BUSY) begin
            bad++; $display("FAIL basic_state_busy: got=%0d exp=%0d", o_state, BUSY);
        end
        i_request   = 5'b00100;
        i_flit_fire = 1'b1;
        i_flit_tail = 1'b1;
        tick();
        i_flit_fire = 1'b0;
        i_flit_tail = 1'b0;
        total++;
        if (o_grant !== 5'b00000) begin
            bad++; $display("FAIL basic_tail_clear: got=%b exp=%b", o_grant, 5'b00000);
        end
        tick();
        total++;
        if (o_grant !== 5'b00100) begin
            bad++; $display("FAIL basic_second_grant: got=%b exp=%b", o_grant, 5'b00100);
        end
    endtask

    task automatic test_rotation();
        logic [4:0] exp_grant;
        do_reset();
        i_request = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_grant = 5'b00001 << (i % 5);
            total++;
            if (o_grant !== exp_grant) begin
                bad++; $display("FAIL rotation_grant_%0d: got=%b exp=%b", i, o_grant, exp_grant);
            end
            i_flit_fire     = 1'b1;
            i_flit_tail     = 1'b1;
            i_credit_return = 2'b01;
            tick();
            i_flit_fire     = 1'b0;
            i_flit_tail     = 1'b0;
            i_credit_return = 2'b00;
            total++;
            if (o_grant !== 5'b00000) begin
                bad++; $display("FAIL rotation_gap_%0d: got=%b exp=%b", i, o_grant, 5'b00000);
            end
        end
        total++;
        if (o_credit_error !== 1'b0) begin
            bad++; $display("FAIL rotation_error: got=%b exp=%b", o_credit_error, 1'b0);
        end
    endtask

    task automatic test_credit_stall();
        do_reset();
        i_request    = 5'b10000;
        i_request_vc = 5'b10000;
        tick();
        total++;
        if (o_grant_vc !== 1'b1) begin
            bad++; $display("FAIL stall_grant_vc: got=%b exp=%b", o_grant_vc, 1'b1);
        end
        i_request   = 5'b00000;
        i_flit_fire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        i_flit_fire = 1'b0;
        total++;
        if (o_vc_available !== 2'b01) begin
            bad++; $display("FAIL stall_vc_empty: got=%b exp=%b", o_vc_available, 2'b01);
        end
        total++;
        if (o_grant !== 5'b10000) begin
            bad++; $display("FAIL stall_grant_held: got=%b exp=%b", o_grant, 5'b10000);
        end
        i_credit_return = 2'b10;
        tick();
        i_credit_return = 2'b00;
        total++;
        if (o_vc_available !== 2'b11) begin
            bad++; $display("FAIL stall_vc_returned: got=%b exp=%b", o_vc_available, 2'b11);
        end
        total++;
        if (o_credit_error !== 1'b0) begin
            bad++; $display("FAIL stall_error: got=%b exp=%b", o_credit_error, 1'b0);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        i_request = 5'b00001;
        tick();
        i_request   = 5'b00000;
        i_flit_fire = 1'b1;
        tick();
        tick();
        // credit now 2; fire and return together must cancel
        i_credit_return = 2'b01;
        tick();
        i_credit_return = 2'b00;
        total++;
        if (o_credit_error !== 1'b0) begin
            bad++; $display("FAIL same_cycle_error: got=%b exp=%b", o_credit_error, 1'b0);
        end
        tick();
        total++;
        if (o_vc_available !== 2'b11) begin
            bad++; $display("FAIL same_cycle_credit1: got=%b exp=%b", o_vc_available, 2'b11);
        end
        tick();
        i_flit_fire = 1'b0;
        total++;
        if (o_vc_available !== 2'b10) begin
            bad++; $display("FAIL same_cycle_credit0: got=%b exp=%b", o_vc_available, 2'b10);
        end
    endtask

    task automatic test_credit_error();
        do_reset();
        i_credit_return = 2'b01;
        tick();
        i_credit_return = 2'b00;
        total++;
        if (o_credit_error !== 1'b1) begin
            bad++; $display("FAIL overflow_error: got=%b exp=%b", o_credit_error, 1'b1);
        end
        tick();
        tick();
        total++;
        if (o_credit_error !== 1'b1) begin
            bad++; $display("FAIL overflow_sticky: got=%b exp=%b", o_credit_error, 1'b1);
        end
        do_reset();
        total++;
        if (o_credit_error !== 1'b0) begin
            bad++; $display("FAIL error_cleared: got=%b exp=%b", o_credit_error, 1'b0);
        end
        i_flit_fire = 1'b1;
        tick();
        i_flit_fire = 1'b0;
        total++;
        if (o_credit_error !== 1'b1) begin
            bad++; $display("FAIL idle_fire_error: got=%b exp=%b", o_credit_error, 1'b1);
        end
        // idle fire must not have consumed credit: 4 granted fires empty VC 0
        i_request = 5'b00010;
        tick();
        i_request   = 5'b00000;
        i_flit_fire = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (o_vc_available !== 2'b11) begin
            bad++; $display("FAIL idle_fire_no_debit: got=%b exp=%b", o_vc_available, 2'b11);
        end
        i_flit_fire = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        i_request = 5'b00001;
        tick();
        i_request   = 5'b00000;
        i_flit_fire = 1'b1;
        tick();
        tick();
        tick();
        i_flit_fire = 1'b0;
        rst_n       = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (o_grant !== 5'b00000) begin
            bad++; $display("FAIL midreset_grant: got=%b exp=%b", o_grant, 5'b00000);
        end
        total++;
        if (o_vc_available !== 2'b11) begin
            bad++; $display("FAIL midreset_vc_available: got=%b exp=%b", o_vc_available, 2'b11);
        end
        total++;
        if (o_state !== IDLE) begin
            bad++; $display("FAIL midreset_state: got=%0d exp=%0d", o_state, IDLE);
        end
        // full DEPTH restored: exactly four fires are needed to empty VC 0
        i_request = 5'b00001;
        tick();
        i_request   = 5'b00000;
        i_flit_fire = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (o_vc_available !== 2'b11) begin
            bad++; $display("FAIL midreset_three_fires: got=%b exp=%b", o_vc_available, 2'b11);
        end
        tick();
        i_flit_fire = 1'b0;
        total++;
        if (o_vc_available !== 2'b10) begin
            bad++; $display("FAIL midreset_four_fires: got=%b exp=%b", o_vc_available, 2'b10);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_grant();
        test_rotation();
        test_credit_stall();
        test_same_cycle();
        test_credit_error();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
